// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 register block: register numbers, exception codes,
// Status/Cause bit positions and the per-cycle update-source selector.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_BEV = 22;
    localparam int CA_TI  = 30;
    localparam int CA_BD  = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_EXC,
        UPD_ERET,
        UPD_MTC0
    } upd_e;

    // One architectural update per cycle: exception beats ERET beats MTC0.
    function automatic upd_e upd_select(input logic exc_valid, input logic eret,
                                        input logic mtc0_we);
        if (exc_valid)    return UPD_EXC;
        else if (eret)    return UPD_ERET;
        else if (mtc0_we) return UPD_MTC0;
        else              return UPD_NONE;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare register and sticky
// timer interrupt TI. Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int COUNT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_we,
    input  logic             compare_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] compare,
    output logic             ti
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] prescale;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            compare  <= '0;
            prescale <= '0;
            ti       <= 1'b0;
        end else begin
            if (count_we) begin
                count    <= wdata;
                prescale <= '0;
            end else if (prescale == PS_LAST) begin
                count    <= count + WIDTH'(1);
                prescale <= '0;
            end else begin
                prescale <= prescale + PW'(1);
            end

            // A Compare write acknowledges the interrupt and wins over a coincident match.
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare && compare != '0) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_core.sv
// MIPS CP0 register block with precise exception commit, ERET and interrupt request.
// Define CP0_TIMER_EN to include the Count/Compare timer (registers 9 and 11, TI).
module cp0_core
    import cp0_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          HW_INT     = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HW_INT-1:0] hw_int,
    input  logic              mtc0_we,
    input  logic [4:0]        waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [4:0]        raddr,
    output logic [WIDTH-1:0]  rdata,
    input  logic              exc_valid,
    input  logic [4:0]        exc_code,
    input  logic              exc_bd,
    input  logic [WIDTH-1:0]  exc_pc,
    input  logic              exc_bad_we,
    input  logic [WIDTH-1:0]  exc_badvaddr,
    input  logic              eret,
    output logic              int_req,
    output logic [WIDTH-1:0]  epc_out,
    output logic [WIDTH-1:0]  status_out,
    output logic [WIDTH-1:0]  cause_out,
    output logic              timer_int
);

    upd_e              upd;
    logic              mtc0_go;
    logic [WIDTH-1:0]  status_q;
    logic [WIDTH-1:0]  epc_q;
    logic [WIDTH-1:0]  badvaddr_q;
    logic              bd_q;
    logic [4:0]        exc_code_q;
    logic [1:0]        sw_ip_q;
    logic [HW_INT-1:0] hw_ip_q;
    logic [5:0]        hw6;
    logic [7:0]        ip;
    logic [WIDTH-1:0]  count;
    logic [WIDTH-1:0]  compare;
    logic              ti;

    assign upd     = upd_select(exc_valid, eret, mtc0_we);
    assign mtc0_go = (upd == UPD_MTC0);

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .WIDTH     (WIDTH),
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_go && waddr == CP0_COUNT),
        .compare_we (mtc0_go && waddr == CP0_COMPARE),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= WIDTH'(STATUS_RESET);
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            sw_ip_q    <= '0;
            hw_ip_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of its neighbours.
            hw_ip_q <= hw_int;
            case (upd)
                UPD_EXC: begin
                    if (!status_q[ST_EXL]) begin
                        epc_q <= exc_pc;
                        bd_q  <= exc_bd;
                    end
                    exc_code_q       <= exc_code;
                    status_q[ST_EXL] <= 1'b1;
                    if (exc_bad_we) badvaddr_q <= exc_badvaddr;
                end
                UPD_ERET: status_q[ST_EXL] <= 1'b0;
                UPD_MTC0: begin
                    case (waddr)
                        CP0_STATUS: status_q <= (status_q & ~WIDTH'(STATUS_WMASK))
                                              | (wdata & WIDTH'(STATUS_WMASK));
                        CP0_CAUSE:  sw_ip_q  <= wdata[9:8];
                        CP0_EPC:    epc_q    <= wdata;
                        default:    ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Zero-extend the sampled lines to the six hardware IP slots.
    always_comb begin
        hw6             = '0;
        hw6[HW_INT-1:0] = hw_ip_q;
    end

    assign ip        = {hw6[5] | ti, hw6[4:0], sw_ip_q};
    assign cause_out = WIDTH'({bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0});
    assign status_out = status_q;
    assign epc_out    = epc_q;
    assign timer_int  = ti;
    assign int_req    = status_q[ST_IE] & ~status_q[ST_EXL] & |(ip & status_q[15:8]);

    always_comb begin
        // NOTE: default first so unlisted addresses cannot infer a latch.
        rdata = '0;
        if (!rst) begin
            case (raddr)
                CP0_BADVADDR: rdata = badvaddr_q;
                CP0_COUNT:    rdata = count;
                CP0_COMPARE:  rdata = compare;
                CP0_STATUS:   rdata = status_q;
                CP0_CAUSE:    rdata = cause_out;
                CP0_EPC:      rdata = epc_q;
                CP0_PRID:     rdata = WIDTH'(PRID_VALUE);
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/cp0_core.md
Name: cp0_core

Overview:
- Second-generation MIPS CP0 register block, parametrised in hardware interrupt count and Count prescale.
- Adds Count/Compare timer interrupt, precise exception commit, and ERET.
- Adds an interrupt request output for the pipeline's exception unit.
- Sits beside the MEM/WB commit stage; MFC0 reads are combinational, all updates are synchronous.

Parameters:
- WIDTH, 32, data width of every CP0 register.
- HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT-1:2].
- COUNT_DIV, 2, clock cycles per Count increment (>=1).
- PRID_VALUE, 32'h0000_4220, constant returned for PRId (reg 15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- hw_int  in  HW_INT  level hardware interrupt lines
- mtc0_we  in  1  MTC0 commit strobe
- waddr  in  5  MTC0 register number
- wdata  in  WIDTH  MTC0 data
- raddr  in  5  MFC0 register number
- rdata  out  WIDTH  MFC0 data, combinational
- exc_valid  in  1  exception commit strobe
- exc_code  in  5  ExcCode of committing exception
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_pc  in  WIDTH  PC of faulting instruction
- exc_bad_we  in  1  update BadVAddr with exc_badvaddr
- exc_badvaddr  in  WIDTH  faulting virtual address
- eret  in  1  ERET commit strobe
- int_req  out  1  interrupt pending and enabled
- epc_out  out  WIDTH  current EPC, for the ERET target
- status_out  out  WIDTH  current Status
- cause_out  out  WIDTH  current Cause
- timer_int  out  1  Cause.TI

Behaviour:
- Reset values (asynchronous):
  - Status = 32'h0040_0000 (BEV=1, all else 0).
  - Cause, EPC, BadVAddr, Count, Compare = 0; prescaler = 0.
  - rdata = 0 while rst is high; int_req = 0; timer_int = 0.
- Registers:
  - 8 BadVAddr: read-only to MTC0.
  - 9 Count.
  - 11 Compare.
  - 12 Status: writable bits IM[15:8], EXL[1], IE[0].
  - 13 Cause: writable bits IP[9:8] only.
  - 14 EPC.
  - 15 PRId: constant.
  - Other addresses read 0; writes to them are ignored.
- Cause layout: BD[31], TI[30], IP[15:8], ExcCode[6:2].
  - IP[2+HW_INT-1:2] is registered from hw_int every cycle (1-cycle latency).
  - IP7 = hw_int[5] OR TI (when HW_INT=6), else IP7 = TI.
- Count:
  - Increments by 1 when the prescaler reaches COUNT_DIV-1; the prescaler then wraps to 0.
  - 32'hFFFF_FFFF + 1 wraps to 0.
  - An MTC0 write to Count loads wdata and clears the prescaler; it has priority over the increment in the same cycle.
- Timer:
  - TI is set on the cycle after Count == Compare with Compare != 0.
  - TI stays set until an MTC0 write to Compare; a Compare write clears TI in the same cycle, and that write wins over a coincident match.
- Update priority, one per cycle: exc_valid > eret > mtc0_we. A lower-priority strobe in the same cycle is dropped.
  - The Count/prescaler and hw_int sampling paths always run.
- exc_valid:
  - If Status.EXL == 0: EPC <= exc_pc and BD <= exc_bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - In both cases: ExcCode <= exc_code, EXL <= 1.
  - BadVAddr <= exc_badvaddr only when exc_bad_we is 1.
- eret: EXL <= 0; nothing else changes.
- int_req = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]). Combinational from registers; no dependency on the current-cycle strobes.
- MFC0 has no write bypass: rdata shows the pre-update value in the cycle of a write.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare/TI behave as described above.
- Undefined:
  - Count and Compare are not implemented; registers 9 and 11 read 0 and writes are ignored.
  - TI and timer_int are constant 0; IP7 = hw_int[5] only.
  - The prescaler logic is removed.

Decomposition:
- Shared package cp0_pkg:
  - Register number constants (CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15).
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12).
  - Status/Cause bit index constants.
- Sub-module cp0_timer (Count, prescaler, Compare, TI).
  - Instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset pulse mid-run → rdata(12)=32'h0040_0000; rdata(13)=0; Count=0; int_req=0 with no clock edge required.
- COUNT_DIV=2, run 10 cycles after reset → rdata(9)=5.
  - MTC0 Count=32'hFFFF_FFFF, then 2 cycles → Count=0.
- MTC0 Compare=20, Count=18 → TI=1 and int_req=0 (IE=0).
  - MTC0 Status=32'h0000_8001 → int_req=1.
  - MTC0 Compare=40 → TI=0 and int_req=0 next cycle.
- exc_valid with exc_pc=32'hBFC0_0100, code=4, bd=1, bad_we=1, badvaddr=32'h1234_5679 → EPC=32'hBFC0_0100, Cause[6:2]=4, BD=1, BadVAddr=32'h1234_5679, EXL=1.
  - A second exc_valid with exc_pc=32'h8000_0000 → EPC unchanged.
- Simultaneous exc_valid, eret and MTC0 EPC=32'h0 → exception applied, EXL=1, EPC=exc_pc.
  - eret alone next cycle → EXL=0.
- hw_int[2]=1 with Status=32'h0000_1001 → Cause.IP4 set one cycle later; int_req=1.
  - Drop hw_int → int_req=0 one cycle later.
